skewed_input_buffer: RTL and testbench
======================================

Name: skewed_input_buffer

Overview:
- Parametrised successor to the fixed per-row activation shifter bank that feeds the systolic array's west edge.
- Accepts activation vectors (one element per row lane) over a valid/ready load port and stores up to DEPTH vectors.
- On a start command it streams the stored tile into the array. In skewed mode lane i is delayed by i cycles and padded with zeros; in aligned mode there is no delay.
- Adds flow control, a variable tile length, backpressure on the stream side and a replay option.

Parameters:
- ROWS, 4, number of row lanes (array height).
- DW, 8, bits per activation element.
- DEPTH, 16, maximum vectors per tile (K dimension); power of two ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_valid  in  1  load vector present.
- load_ready  out  1  buffer can accept a vector.
- load_data  in  ROWS*DW  vector; lane i at bits [(i+1)*DW-1 : i*DW].
- start  in  1  begin streaming the stored tile (single-cycle pulse).
- skew_en  in  1  sampled at start: 1 = skewed, 0 = aligned.
- keep  in  1  sampled at start: 1 = retain tile after stream for replay.
- out_valid  out  1  out_data is a valid array column.
- out_ready  in  1  array consumes the column this cycle.
- out_data  out  ROWS*DW  streamed column, same lane packing as load_data.
- busy  out  1  high in STREAM.
- done  out  1  one-cycle pulse on the final accepted column.
- fill_cnt  out  $clog2(DEPTH+1)  vectors currently stored.

Behaviour:
- Reset (rst=1 at a clk edge) forces:
  - state = IDLE;
  - fill_cnt, step counter t, busy, done, out_valid and out_data = 0;
  - load_ready = 1.
  - Storage contents are not reset.
  - Reset mid-stream aborts immediately; the next cycle behaves as a fresh IDLE.
- IDLE:
  - load_ready = (fill_cnt < DEPTH) && !start.
  - A load handshake writes load_data at address fill_cnt; fill_cnt increments next cycle.
  - When full, load_ready = 0 and extra load_valid is ignored without error.
  - start with fill_cnt = 0 is ignored (no busy, no done).
  - start with fill_cnt = L > 0:
    - latch len = L and latch skew_en and keep;
    - t = 0;
    - enter STREAM next cycle.
  - start and load_valid in the same cycle: start wins and no load occurs.
- STREAM:
  - busy = 1, out_valid = 1, load_ready = 0.
  - start, load_valid and skew_en are ignored.
  - out_data is driven from registered t and the storage.
    - Skewed: lane i = mem_i[t-i] if i ≤ t < i+len, otherwise 0.
    - Aligned: lane i = mem_i[t].
  - The last step is T = len+ROWS-2 when skewed, T = len-1 when aligned.
  - On out_valid && out_ready with t < T: t increments.
  - On out_valid && out_ready with t = T:
    - done = 1 in that same cycle (combinational with the final handshake);
    - return to IDLE next cycle with t = 0.
  - With out_ready = 0, t, out_data and out_valid hold (stall of any length).
- Stream exit:
  - keep = 0: fill_cnt clears to 0 on exit.
  - keep = 1: fill_cnt retains len, so a later start replays the identical tile.
  - Loads after a keep stream append at address fill_cnt.
- Latency:
  - start to first out_valid is 1 cycle.
  - A skewed stream of len vectors with out_ready held high lasts len+ROWS-1 cycles; aligned lasts len cycles.
- Widths:
  - t is $clog2(DEPTH+ROWS) bits.
  - Lane read index t-i is computed in width t+1 and compared unsigned after a range check, so there is no wrap-around.

Decomposition:
- Shared package holds:
  - state encoding IDLE/STREAM;
  - the default ROWS/DW/DEPTH constants, replacing the current global ARRAYWIDTH/DATASIZE macros;
  - a clog2-derived counter width constant.
- One natural sub-module, skew_lane, instantiated per lane with lane index LANE as a parameter:
  - DEPTH×DW storage;
  - write port;
  - skewed read with zero padding, given t, len and skew_en.
- The top level holds the FSM, counters and handshakes.

Test Plan (ROWS=4, DW=8, DEPTH=8):
- Reset then load 3 vectors (lane i of vector k = 0x10*k+i), start with skew_en=1, out_ready=1:
  - 6 columns;
  - lane0 = 00,10,20,0,0,0; lane3 = 0,0,0,03,13,23;
  - done on the 6th column; fill_cnt then 0.
- Same load, skew_en=0:
  - 3 columns equal to the loaded vectors;
  - done on the 3rd.
- Load 8 vectors:
  - load_ready drops after the 8th;
  - a 9th load_valid is ignored and fill_cnt = 8.
  - Skewed stream lasts 11 columns with the correct lane-3 tail.
- Skewed stream with out_ready toggling 1,0,0,1…:
  - each column holds across stalls;
  - total accepted columns = len+3;
  - no duplication or skipping.
- keep=1 stream of 2 vectors:
  - fill_cnt stays 2;
  - second start replays identical columns;
  - start with fill_cnt=0 produces no busy.
- Assert rst during column 2 of a stream:
  - next cycle busy=0, out_valid=0, fill_cnt=0;
  - a fresh load+start behaves normally.

Source files
------------

// File: rtl/skewed_input_buffer_pkg.sv
// skewed_input_buffer_pkg: shared defaults, state encoding and counter widths for the skewed input buffer
package skewed_input_buffer_pkg;
  localparam int ROWS_D = 4;
  localparam int DW_D = 8;
  localparam int DEPTH_D = 16;
  localparam int TW_D = $clog2(DEPTH_D + ROWS_D);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;
endpackage

// File: rtl/skewed_input_buffer_lane.sv
// skew_lane: per-lane tile storage with a skewed, zero-padded read port
module skew_lane
  import skewed_input_buffer_pkg::*;
#(
  parameter int LANE = 0,
  parameter int DW = DW_D,
  parameter int DEPTH = DEPTH_D,
  parameter int TW = TW_D,
  parameter int CW = $clog2(DEPTH_D + 1),
  parameter int AW = $clog2(DEPTH_D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [TW-1:0] t,
  input  logic [CW-1:0] len,
  input  logic          skew,
  output logic [DW-1:0] data
);
  logic [DW-1:0] mem [DEPTH];
  logic [TW:0] idx;
  logic in_range;
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // one extra bit keeps t-LANE from wrapping before the range check
  always_comb begin
    idx = {1'b0, t} - (TW+1)'(LANE);
    in_range = ({1'b0, t} >= (TW+1)'(LANE)) && (idx < (TW+1)'(len));
    data = skew ? (in_range ? mem[idx[AW-1:0]] : '0) : mem[t[AW-1:0]];
  end
endmodule

// File: rtl/skewed_input_buffer.sv
// skewed_input_buffer: buffers an activation tile and streams it skewed or aligned into the array
module skewed_input_buffer
  import skewed_input_buffer_pkg::*;
#(
  parameter int ROWS = ROWS_D,
  parameter int DW = DW_D,
  parameter int DEPTH = DEPTH_D
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic [ROWS*DW-1:0]           load_data,
  input  logic                         start,
  input  logic                         skew_en,
  input  logic                         keep,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ROWS*DW-1:0]           out_data,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fill_cnt
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH + ROWS);
  localparam int AW = $clog2(DEPTH);
  logic [0:0] state;
  logic [TW-1:0] t, last_t;
  logic [CW-1:0] len;
  logic skew_q, keep_q, ld, fire;
  logic [ROWS*DW-1:0] lanes;
  always_comb begin
    busy = state == STREAM;
    out_valid = busy;
    load_ready = !busy && (fill_cnt < CW'(DEPTH)) && !start;
    ld = load_valid && load_ready;
    fire = busy && out_ready;
    last_t = skew_q ? TW'(len) + TW'(ROWS - 2) : TW'(len) - TW'(1);
    done = fire && (t == last_t);
    out_data = busy ? lanes : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      fill_cnt <= '0;
      t <= '0;
      len <= '0;
      skew_q <= 1'b0;
      keep_q <= 1'b0;
    end else if (state == IDLE) begin
      if (start && fill_cnt != '0) begin
        state <= STREAM;
        len <= fill_cnt;
        skew_q <= skew_en;
        keep_q <= keep;
        t <= '0;
      end else if (ld) fill_cnt <= fill_cnt + CW'(1);
    end else if (fire) begin
      t <= done ? '0 : t + TW'(1);
      if (done) state <= IDLE;
      if (done && !keep_q) fill_cnt <= '0;
    end
  for (genvar i = 0; i < ROWS; i++) begin : g_lane
    skew_lane #(.LANE(i), .DW(DW), .DEPTH(DEPTH), .TW(TW), .CW(CW), .AW(AW)) u_lane (
      .clk(clk),
      .we(ld),
      .waddr(fill_cnt[AW-1:0]),
      .wdata(load_data[i*DW +: DW]),
      .t(t),
      .len(len),
      .skew(skew_q),
      .data(lanes[i*DW +: DW])
    );
  end
endmodule

// File: tb/tb_skewed_input_buffer.sv
// tb_skewed_input_buffer: directed self-checking bench for skewed_input_buffer (ROWS=4, DW=8, DEPTH=8)
module tb_skewed_input_buffer;
  localparam int ROWS = 4;
  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH + 1);
  logic clk = 1'b0;
  logic rst, load_valid, load_ready, start, skew_en, keep, out_valid, out_ready, busy, done;
  logic [ROWS*DW-1:0] load_data, out_data;
  logic [CW-1:0] fill_cnt;
  int n_assert = 0;
  int n_fail = 0;

  skewed_input_buffer #(.ROWS(ROWS), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .start(start), .skew_en(skew_en), .keep(keep), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy), .done(done), .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // expected column: vector k lane i holds base+0x10*k+i; skewed lanes read vector t-i, zero outside the tile
  function automatic logic [31:0] exp_col(input int t, input int len, input bit sk, input int base);
    logic [31:0] r;
    int k;
    r = '0;
    for (int i = 0; i < ROWS; i++) begin
      k = sk ? t - i : t;
      if (k >= 0 && k < len) r[i*DW +: DW] = 8'(base + 16*k + i);
    end
    return r;
  endfunction

  task automatic load_vecs(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      load_valid = 1'b1;
      for (int i = 0; i < ROWS; i++) load_data[i*DW +: DW] = 8'(base + 16*k + i);
      #1;
      check("load_ready", 32'(load_ready), 32'd1);
      step();
    end
    load_valid = 1'b0;
    #1;
    check("fill_after_load", 32'(fill_cnt), 32'(n));
  endtask

  task automatic run_stream(input int len, input bit sk, input bit kp, input bit stall, input int base, input int fill_after);
    int ncols, c, cyc;
    ncols = sk ? len + ROWS - 1 : len;
    c = 0;
    cyc = 0;
    start = 1'b1;
    skew_en = sk;
    keep = kp;
    load_valid = 1'b1;
    #1;
    check("load_ready_at_start", 32'(load_ready), 32'd0);
    step();
    start = 1'b0;
    skew_en = ~sk;
    while (c < ncols && cyc < 200) begin
      out_ready = stall ? (cyc % 3 == 0) : 1'b1;
      #1;
      check("busy", 32'(busy), 32'd1);
      check("out_valid", 32'(out_valid), 32'd1);
      check($sformatf("col%0d", c), out_data, exp_col(c, len, sk, base));
      check("done", 32'(done), 32'(out_ready && c == ncols - 1));
      if (out_ready) c++;
      step();
      cyc++;
    end
    load_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("cols_accepted", 32'(c), 32'(ncols));
    check("busy_after", 32'(busy), 32'd0);
    check("fill_after_stream", 32'(fill_cnt), 32'(fill_after));
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; skew_en = 1'b0; keep = 1'b0; out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_fill", 32'(fill_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    // skewed 3-vector tile: lane0 = 00,10,20,0,0,0 and lane3 = 0,0,0,03,13,23
    load_vecs(3, 0);
    run_stream(3, 1'b1, 1'b0, 1'b0, 0, 0);
    load_vecs(3, 0);
    run_stream(3, 1'b0, 1'b0, 1'b0, 0, 0);
    // full buffer: ninth load ignored, 11 skewed columns
    load_vecs(8, 0);
    load_valid = 1'b1;
    #1;
    check("full_load_ready", 32'(load_ready), 32'd0);
    step();
    load_valid = 1'b0;
    #1;
    check("full_fill", 32'(fill_cnt), 32'd8);
    run_stream(8, 1'b1, 1'b0, 1'b0, 0, 0);
    load_vecs(5, 8'h20);
    run_stream(5, 1'b1, 1'b0, 1'b1, 8'h20, 0);
    // keep then replay, then start on an empty buffer
    load_vecs(2, 8'h80);
    run_stream(2, 1'b1, 1'b1, 1'b0, 8'h80, 2);
    run_stream(2, 1'b1, 1'b0, 1'b0, 8'h80, 0);
    start = 1'b1;
    skew_en = 1'b1;
    #1;
    check("empty_start_done", 32'(done), 32'd0);
    step();
    start = 1'b0;
    #1;
    check("empty_start_busy", 32'(busy), 32'd0);
    check("empty_start_valid", 32'(out_valid), 32'd0);
    // reset while the second column is presented
    load_vecs(3, 8'h40);
    start = 1'b1;
    step();
    start = 1'b0;
    #1;
    check("pre_rst_col0", out_data, exp_col(0, 3, 1'b1, 8'h40));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_fill", 32'(fill_cnt), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_load_ready", 32'(load_ready), 32'd1);
    load_vecs(4, 8'h50);
    run_stream(4, 1'b1, 1'b0, 1'b0, 8'h50, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
